// File: rtl/tdf_stream_pkg.sv
// Shared definitions for the TDF stream queue family.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package tdf_stream_pkg;

  // Ceiling log2 used to size pointers and the occupancy count.
  // Returns at least 1 so that single-bit fields never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Stored entries are {e, d}: the end-of-stream flag sits just above the data MSB.
  function automatic int eIndex(input int width);
    return width;
  endfunction

  // DEPTH must be at least 2.
  // SLACK must leave at least one free slot before back-pressure rises.
  function automatic bit paramsLegal(input int depth, input int slack);
    return (depth >= 2) && (slack >= 0) && (slack <= depth - 1);
  endfunction

endpackage

// File: rtl/tdf_queue_mem.sv
// DEPTH x (WIDTH+1) token storage with one write port and one asynchronous read port.
// Latency: a write is visible on the read port the cycle after it is clocked in.
// Backpressure: none here; the caller decides when to write.
module tdf_queue_mem
  import tdf_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      wrEn,
  input  logic [clog2(DEPTH)-1:0]   wrAddr,
  input  logic [WIDTH:0]            wrData,
  input  logic [clog2(DEPTH)-1:0]   rdAddr,
  output logic [WIDTH:0]            rdData
);

  logic [WIDTH:0] slots [DEPTH];

  // Storage has no reset; occupancy tracking makes stale slots unobservable.
  always_ff @(posedge clock) begin
    if (wrEn) slots[wrAddr] <= wrData;
  end

  assign rdData = slots[rdAddr];

endmodule

// File: rtl/tdf_stream_queue.sv
// First-word-fall-through token queue between a TDF operator and its consumer.
// Latency: a token pushed in cycle t appears at the head in t+1; there is no bypass path.
// Backpressure: in_b rises at DEPTH-SLACK entries; tokens arriving while full are dropped and flagged.
module tdf_stream_queue
  import tdf_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int SLACK = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            in_d,
  input  logic                        in_e,
  input  logic                        in_v,
  output logic                        in_b,
  output logic [WIDTH-1:0]            out_d,
  output logic                        out_e,
  output logic                        out_v,
  input  logic                        out_b,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        overflow,
  output logic                        eos_seen
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam int E_BIT = eIndex(WIDTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] BUSY_COUNT = CW'(DEPTH - SLACK);
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

  if (!paramsLegal(DEPTH, SLACK)) begin : gBadParams
    $error("tdf_stream_queue: need DEPTH >= 2 and 0 <= SLACK <= DEPTH-1");
  end

  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [WIDTH:0] headEntry;
  logic          isFull;
  logic          doPop;
  logic          doPush;
  logic          doDrop;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push then.
  always_comb begin
    isFull = (count == FULL_COUNT);
    doPop  = out_v && !out_b;
    doPush = in_v && (!isFull || doPop);
    doDrop = in_v && isFull && !doPop;
  end

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= (wrPtr == LAST_SLOT) ? '0 : wrPtr + AW'(1);
      if (doPop)  rdPtr <= (rdPtr == LAST_SLOT) ? '0 : rdPtr + AW'(1);
    end
  end

  // Occupancy moves only when exactly one of push/pop happens.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (doPush && !doPop) begin
      count <= count + CW'(1);
    end else if (doPop && !doPush) begin
      count <= count - CW'(1);
    end
  end

  // Sticky status: lost tokens and end-of-stream delivery.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      eos_seen <= 1'b0;
    end else begin
      if (doDrop) overflow <= 1'b1;
      if (doPop && out_e) eos_seen <= 1'b1;
    end
  end

  tdf_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) uMem (
    .clock  (clock),
    .wrEn   (doPush),
    .wrAddr (wrPtr),
    .wrData ({in_e, in_d}),
    .rdAddr (rdPtr),
    .rdData (headEntry)
  );

  // Handshake outputs decode registered state only.
  assign out_v = (count != '0);
  assign in_b  = (count >= BUSY_COUNT);
  assign out_e = headEntry[E_BIT];
  assign out_d = headEntry[WIDTH-1:0];

endmodule

// File: tb/tb_tdf_stream_queue.sv
module tb_tdf_stream_queue;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Instance A: WIDTH=16, DEPTH=4, SLACK=1
  logic [15:0] aInD, aOutD;
  logic        aInE, aInV, aInB, aOutE, aOutV, aOutB, aOvf, aEos;
  logic [2:0]  aCount;
  // Instance B: WIDTH=16, DEPTH=3, SLACK=0
  logic [15:0] bInD, bOutD;
  logic        bInE, bInV, bInB, bOutE, bOutV, bOutB, bOvf, bEos;
  logic [1:0]  bCount;

  tdf_stream_queue #(.WIDTH(16), .DEPTH(4), .SLACK(1)) dutA (
    .clock(clock), .reset(reset),
    .in_d(aInD), .in_e(aInE), .in_v(aInV), .in_b(aInB),
    .out_d(aOutD), .out_e(aOutE), .out_v(aOutV), .out_b(aOutB),
    .count(aCount), .overflow(aOvf), .eos_seen(aEos)
  );

  tdf_stream_queue #(.WIDTH(16), .DEPTH(3), .SLACK(0)) dutB (
    .clock(clock), .reset(reset),
    .in_d(bInD), .in_e(bInE), .in_v(bInV), .in_b(bInB),
    .out_d(bOutD), .out_e(bOutE), .out_v(bOutV), .out_b(bOutB),
    .count(bCount), .overflow(bOvf), .eos_seen(bEos)
  );

  int nCompared = 0;
  int nMismatch = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: an ordered list of {e,d} tokens per instance plus sticky flags.
  logic [16:0] mq [2][$];
  int mDepth [2] = '{4, 3};
  int mSlack [2] = '{1, 0};
  bit mOvf [2];
  bit mEos [2];
  int dutPops [2];

  task automatic clearModel();
    for (int w = 0; w < 2; w++) begin
      mq[w].delete();
      mOvf[w] = 1'b0;
      mEos[w] = 1'b0;
    end
  endtask

  task automatic setIn(input int w, input bit iv, input bit ie, input logic [15:0] id, input bit ob);
    if (w == 0) begin
      aInV = iv; aInE = ie; aInD = id; aOutB = ob;
    end else begin
      bInV = iv; bInE = ie; bInD = id; bOutB = ob;
    end
  endtask

  // One clock cycle on instance w: drive, check registered outputs, advance model.
  task automatic step(input int w, input bit iv, input bit ie, input logic [15:0] id, input bit ob);
    string p;
    logic oV, oE, iB, ovf, eos;
    logic [15:0] oD;
    int cnt;
    bit pop, push;
    p = (w == 0) ? "A." : "B.";
    setIn(w, iv, ie, id, ob);
    #1;
    if (w == 0) begin
      oV = aOutV; oE = aOutE; oD = aOutD; iB = aInB; ovf = aOvf; eos = aEos; cnt = int'(aCount);
    end else begin
      oV = bOutV; oE = bOutE; oD = bOutD; iB = bInB; ovf = bOvf; eos = bEos; cnt = int'(bCount);
    end
    chk({p, "out_v"}, oV, mq[w].size() != 0);
    chk({p, "count"}, cnt, mq[w].size());
    chk({p, "in_b"}, iB, mq[w].size() >= mDepth[w] - mSlack[w]);
    chk({p, "overflow"}, ovf, mOvf[w]);
    chk({p, "eos_seen"}, eos, mEos[w]);
    if (mq[w].size() != 0) begin
      chk({p, "out_e"}, oE, mq[w][0][16]);
      if (!mq[w][0][16]) chk({p, "out_d"}, oD, mq[w][0][15:0]);
    end
    if (oV && !ob) dutPops[w]++;
    pop  = (mq[w].size() != 0) && !ob;
    push = iv && ((mq[w].size() < mDepth[w]) || pop);
    @(posedge clock);
    if (pop) begin
      if (mq[w][0][16]) mEos[w] = 1'b1;
      void'(mq[w].pop_front());
    end
    if (push) mq[w].push_back({ie, id});
    else if (iv) mOvf[w] = 1'b1;
    @(negedge clock);
    setIn(w, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  int sent;
  bit rv;

  initial begin
    setIn(0, 1'b0, 1'b0, 16'h0, 1'b1);
    setIn(1, 1'b0, 1'b0, 16'h0, 1'b1);
    clearModel();
    dutPops[0] = 0;
    dutPops[1] = 0;

    // Reset values
    #3;
    chk("rst.A.out_v", aOutV, 0);
    chk("rst.A.count", aCount, 0);
    chk("rst.A.in_b", aInB, 0);
    chk("rst.A.overflow", aOvf, 0);
    chk("rst.A.eos_seen", aEos, 0);
    chk("rst.B.in_b", bInB, 0);
    @(negedge clock);
    reset = 1'b0;

    // Fill with consumer stalled, then drain back-to-back
    for (int i = 1; i <= 4; i++) step(0, 1'b1, 1'b0, 16'(i), 1'b1);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Full: simultaneous push/pop, then an overflowing push, then drain
    for (int i = 1; i <= 4; i++) step(0, 1'b1, 1'b0, 16'(i), 1'b1);
    step(0, 1'b1, 1'b0, 16'h0005, 1'b0);
    step(0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(0, 1'b1, 1'b0, 16'hBEEF, 1'b1);
    for (int i = 0; i < 6; i++) step(0, 1'b0, 1'b0, 16'h0, 1'b0);

    // End-of-stream token in the middle of data
    step(0, 1'b1, 1'b0, 16'h0010, 1'b1);
    step(0, 1'b1, 1'b1, 16'h5A5A, 1'b1);
    step(0, 1'b1, 1'b0, 16'h0011, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Random traffic on A
    for (int i = 0; i < 200; i++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           16'($urandom), $urandom_range(0, 2) == 0);

    // DEPTH=3, SLACK=0: well-behaved producer, ten tokens, random consumer stalls
    dutPops[1] = 0;
    sent = 0;
    for (int c = 0; c < 300 && sent < 10; c++) begin
      rv = (bInB == 1'b0) && ($urandom_range(0, 3) != 0);
      step(1, rv, 1'b0, 16'(100 + sent), $urandom_range(0, 1) == 1);
      if (rv) sent++;
    end
    chk("B.sent", sent, 10);
    for (int c = 0; c < 20 && mq[1].size() != 0; c++) step(1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("B.delivered", dutPops[1], 10);

    // Random traffic on B, ignoring in_b so wrap and overflow both occur
    for (int i = 0; i < 200; i++)
      step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           16'($urandom), $urandom_range(0, 1) == 1);

    // Asynchronous reset with tokens queued
    step(0, 1'b1, 1'b0, 16'h0021, 1'b1);
    step(0, 1'b1, 1'b0, 16'h0022, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.A.out_v", aOutV, 0);
    chk("arst.A.count", aCount, 0);
    chk("arst.A.overflow", aOvf, 0);
    chk("arst.A.eos_seen", aEos, 0);
    chk("arst.B.count", bCount, 0);
    @(negedge clock);
    reset = 1'b0;
    clearModel();
    step(0, 1'b1, 1'b0, 16'h0007, 1'b0);
    step(0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(0, 1'b0, 1'b0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
